// File: rtl/pipe_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types for the pipeline stall/flush sequencer:
//   state_e       - sequencer FSM states
//   stall_cause_e - winning hazard for the current cycle, kept for debug
//   bank_ctrl_t   - enable/clear bundle for the five pipeline register banks
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_MEM_WAIT,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_MEM,
        CAUSE_FLUSH,
        CAUSE_LOAD_USE,
        CAUSE_IFETCH
    } stall_cause_e;

    typedef struct packed {
        logic en_f;
        logic en_d;
        logic en_e;
        logic en_m;
        logic en_w;
        logic clr_d;
        logic clr_e;
        logic clr_m;
        logic clr_w;
    } bank_ctrl_t;

    // Free-running pipeline: every bank updates, nothing cleared.
    localparam bank_ctrl_t CTRL_FLOW   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                           1'b0, 1'b0, 1'b0, 1'b0};
    // Every bank holds its contents.
    localparam bank_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                           1'b0, 1'b0, 1'b0, 1'b0};
    // Bubble-fill after reset: PC held, every stage register cleared.
    localparam bank_ctrl_t CTRL_BOOT   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                           1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Purely combinational hazard prioritiser. Maps the pipeline status inputs to
// the winning stall cause and the bank-control bundle used while running.
// Priority: data-memory wait > EX redirect > load-use > fetch wait.
//   rs1_d, rs2_d : source registers of the instruction in ID
//   rd_e, load_e : destination / load flag of the instruction in EX
//   pc_src_e     : redirect resolved in EX
//   imem_ready   : fetch data valid
//   dmem_req_m   : MEM-stage instruction accesses data memory
//   dmem_ready   : data memory completes this cycle
//   cause        : winning hazard
//   ctrl         : enable/clear bundle for the running pipeline
// ----------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0]   rs1_d,
    input  logic [4:0]   rs2_d,
    input  logic [4:0]   rd_e,
    input  logic         load_e,
    input  logic         pc_src_e,
    input  logic         imem_ready,
    input  logic         dmem_req_m,
    input  logic         dmem_ready,
    output stall_cause_e cause,
    output bank_ctrl_t   ctrl
);

    logic w_mem_busy;
    logic w_load_use;

    assign w_mem_busy = dmem_req_m & ~dmem_ready;
    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    assign w_load_use = load_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));

    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ctrl  = CTRL_FLOW;
        cause = CAUSE_NONE;
        if (w_mem_busy) begin
            // Full freeze keeps the redirect in EX alive until memory releases.
            ctrl  = CTRL_FREEZE;
            cause = CAUSE_MEM;
        end else if (pc_src_e) begin
            // PC loads the target; the wrong-path instructions in ID and EX die.
            ctrl.clr_d = 1'b1;
            ctrl.clr_e = 1'b1;
            cause      = CAUSE_FLUSH;
        end else if (w_load_use) begin
            ctrl.en_f  = 1'b0;
            ctrl.en_d  = 1'b0;
            ctrl.clr_e = 1'b1;
            cause      = CAUSE_LOAD_USE;
        end else if (!imem_ready) begin
            ctrl.en_f  = 1'b0;
            ctrl.clr_d = 1'b1;
            cause      = CAUSE_IFETCH;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for the five-stage RV32I pipeline.
// Sequences BOOT (bubble fill) -> RUN <-> MEM_WAIT -> HALT (data-memory
// timeout) and overlays the state on the combinational hazard priority.
// Parameters:
//   BOOT_CYCLES    : cycles of bubble fill after reset release (>= 1)
//   TIMEOUT_CYCLES : consecutive data-memory wait cycles before halting (>= 2)
//   CNT_W          : stall counter width
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   rs1_d, rs2_d, rd_e, load_e : load-use operands
//   pc_src_e                   : EX redirect
//   imem_ready                 : fetch ready
//   dmem_req_m, dmem_ready     : MEM-stage access and completion
//   en_f..en_w                 : register-bank enables
//   clr_d..clr_w               : register-bank synchronous clears
//   mem_timeout                : sticky halt flag
//   stall_cnt                  : saturating count of fetch-stall cycles
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_e,
    input  logic             load_e,
    input  logic             pc_src_e,
    input  logic             imem_ready,
    input  logic             dmem_req_m,
    input  logic             dmem_ready,
    output logic             en_f,
    output logic             en_d,
    output logic             en_e,
    output logic             en_m,
    output logic             en_w,
    output logic             clr_d,
    output logic             clr_e,
    output logic             clr_m,
    output logic             clr_w,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [BOOT_W-1:0] BOOT_LOAD = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_e            r_state;
    logic [BOOT_W-1:0] r_boot_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_mem_timeout;

    stall_cause_e w_cause;
    bank_ctrl_t   w_hz_ctrl;
    bank_ctrl_t   w_ctrl;
    logic         w_mem_busy;
    logic         w_running;

    hazard_detect u_hazard_detect (
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rd_e       (rd_e),
        .load_e     (load_e),
        .pc_src_e   (pc_src_e),
        .imem_ready (imem_ready),
        .dmem_req_m (dmem_req_m),
        .dmem_ready (dmem_ready),
        .cause      (w_cause),
        .ctrl       (w_hz_ctrl)
    );

    assign w_mem_busy = (w_cause == CAUSE_MEM);
    assign w_running  = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);

    // State overrides the hazard bundle; outputs stay combinational so the
    // stage registers react on the same edge as the hazard appears.
    always_comb begin
        w_ctrl = w_hz_ctrl;
        case (r_state)
            ST_BOOT: w_ctrl = CTRL_BOOT;
            ST_HALT: w_ctrl = CTRL_FREEZE;
            default: w_ctrl = w_hz_ctrl;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_boot_cnt    <= BOOT_LOAD;
            r_wait_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (r_boot_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_boot_cnt <= r_boot_cnt - BOOT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_mem_busy) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (!w_mem_busy) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state       <= ST_HALT;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase

            // Saturate instead of wrapping so a long run never reads as short.
            if (w_running && !w_ctrl.en_f && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign en_f        = w_ctrl.en_f;
    assign en_d        = w_ctrl.en_d;
    assign en_e        = w_ctrl.en_e;
    assign en_m        = w_ctrl.en_m;
    assign en_w        = w_ctrl.en_w;
    assign clr_d       = w_ctrl.clr_d;
    assign clr_e       = w_ctrl.clr_e;
    assign clr_m       = w_ctrl.clr_m;
    assign clr_w       = w_ctrl.clr_w;
    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;

endmodule
